// File: rtl/stump_mem_responder_pkg.sv
// Shared definitions for the Stump memory responder:
// FSM state encoding, I/O page map and the wait-state limit.
package stump_mem_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACCESS  = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [7:0]  IO_PAGE = 8'hFF;
  localparam logic [15:0] IO_SW   = 16'hFFF0;
  localparam logic [15:0] IO_LED  = 16'hFFF1;

  localparam int unsigned WAIT_MAX = 7;

  function automatic logic is_io(input logic [15:0] a);
    return a[15:8] == IO_PAGE;
  endfunction

endpackage

// File: rtl/stump_mem_responder_sync2.sv
// Two-flop synchronizer for the 16-bit switch port.
// Ports: clk, rst (sync, active-high), d (async in), q (synced out).
module stump_sync2 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d,
  output logic [15:0] q
);

  logic [15:0] s1_q, s1_d;
  logic [15:0] s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/stump_mem_responder.sv
// Stump memory responder: strobes in, sync RAM out, ready pulse back.
// Ports: clk/rst, mem_ren/mem_wen/address/data_out from the core,
// data_in/mem_ready to the core, ram_* to the RAM, sw_in/led_out
// for the I/O page (STUMP_MEM_IO_EN), err is a sticky protocol flag.
module stump_mem_responder
  import stump_mem_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [15:0] address,
  input  logic [15:0] data_out,
  output logic [15:0] data_in,
  output logic        mem_ready,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_re,
  output logic        ram_we,
  input  logic [15:0] ram_rdata,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        err
);

  localparam logic [2:0] WS =
    (WAIT_STATES > WAIT_MAX) ? 3'(WAIT_MAX) : 3'(WAIT_STATES);

  logic [2:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        io_acc;
  logic [15:0] io_rdata;

`ifdef STUMP_MEM_IO_EN
  logic [15:0] sw_sync;
  logic [15:0] led_q, led_d;

  stump_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sw_in),
    .q   (sw_sync)
  );

  assign io_acc = is_io(addr_q);

  always_comb begin
    io_rdata = '0;
    if (addr_q == IO_SW)
      io_rdata = sw_sync;
    else if (addr_q == IO_LED)
      io_rdata = led_q;
  end

  always_comb begin
    led_d = led_q;
    if (state_q == S_ACCESS && we_q && addr_q == IO_LED)
      led_d = wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) led_q <= '0;
    else     led_q <= led_d;
  end

  assign led_out = led_q;
`else
  logic unused_sw;
  assign unused_sw = ^sw_in;
  assign io_acc    = 1'b0;
  assign io_rdata  = '0;
  assign led_out   = '0;
`endif

  // next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (mem_ren | mem_wen) state_d = S_ACCESS;
      S_ACCESS:  state_d = S_CAPTURE;
      S_CAPTURE: state_d = (WS != 3'd0) ? S_WAIT : S_DONE;
      S_WAIT:    if (cnt_q <= 3'd1) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // datapath / registered outputs
  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ready_d = (state_d == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (mem_ren | mem_wen) begin
          // both strobes: treated as a write
          we_d    = mem_wen;
          addr_d  = address;
          wdata_d = data_out;
          if (mem_ren & mem_wen) err_d = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (!we_q) rdata_d = io_acc ? io_rdata : ram_rdata;
        cnt_d = WS;
      end
      S_WAIT:  cnt_d = cnt_q - 3'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // rst gates the strobes so an ACCESS cut by reset never commits
  assign ram_re = (state_q == S_ACCESS) & ~we_q & ~io_acc & ~rst;
  assign ram_we = (state_q == S_ACCESS) &  we_q & ~io_acc & ~rst;

  assign data_in   = rdata_q;
  assign mem_ready = ready_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_stump_mem_responder.sv
// Bench for stump_mem_responder: two instances (0 and 3 wait
// states) share the request inputs, each with its own RAM model.
module tb_stump_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_ren = 1'b0;
  logic        mem_wen = 1'b0;
  logic [15:0] address = '0;
  logic [15:0] data_out = '0;
  logic [15:0] sw_in = '0;

  logic [15:0] d0_data_in, d0_ram_addr, d0_ram_wdata, d0_led, d0_rdata;
  logic        d0_ready, d0_re, d0_we, d0_err;
  logic [15:0] d3_data_in, d3_ram_addr, d3_ram_wdata, d3_led, d3_rdata;
  logic        d3_ready, d3_re, d3_we, d3_err;

  logic [15:0] mem0 [256] = '{default: 16'h0};
  logic [15:0] mem3 [256] = '{default: 16'h0};

  always #5 clk = ~clk;

  stump_mem_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .address(address), .data_out(data_out), .data_in(d0_data_in),
    .mem_ready(d0_ready), .ram_addr(d0_ram_addr),
    .ram_wdata(d0_ram_wdata), .ram_re(d0_re), .ram_we(d0_we),
    .ram_rdata(d0_rdata), .sw_in(sw_in), .led_out(d0_led),
    .err(d0_err)
  );

  stump_mem_responder #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .address(address), .data_out(data_out), .data_in(d3_data_in),
    .mem_ready(d3_ready), .ram_addr(d3_ram_addr),
    .ram_wdata(d3_ram_wdata), .ram_re(d3_re), .ram_we(d3_we),
    .ram_rdata(d3_rdata), .sw_in(sw_in), .led_out(d3_led),
    .err(d3_err)
  );

  // synchronous RAM models, preloaded while rst is high
  always @(posedge clk) begin
    if (rst) begin
      mem0[4] <= 16'hBEEF;
      mem0[8] <= 16'h1357;
    end
    if (d0_we) mem0[d0_ram_addr[7:0]] <= d0_ram_wdata;
    if (d0_re) d0_rdata <= mem0[d0_ram_addr[7:0]];
  end

  always @(posedge clk) begin
    if (rst) begin
      mem3[4] <= 16'hBEEF;
      mem3[8] <= 16'h1357;
    end
    if (d3_we) mem3[d3_ram_addr[7:0]] <= d3_ram_wdata;
    if (d3_re) d3_rdata <= mem3[d3_ram_addr[7:0]];
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // per-transfer observations
  int lat0, lat3, acc0, rdy0n, rdy3n;
  int re0n, we0n, re3n, we3n;
  logic [15:0] rd0, rd3, aseen0, wseen0;

  task automatic xfer(input logic r, input logic w,
                      input logic [15:0] a, input logic [15:0] d);
    lat0 = -1; lat3 = -1; acc0 = -1; rdy0n = 0; rdy3n = 0;
    re0n = 0; we0n = 0; re3n = 0; we3n = 0;
    rd0 = '0; rd3 = '0; aseen0 = '0; wseen0 = '0;
    @(negedge clk);
    mem_ren = r; mem_wen = w; address = a; data_out = d;
    for (int k = 1; k <= 20 && lat3 < 0; k++) begin
      @(negedge clk);
      if (d0_re | d0_we) begin
        if (acc0 < 0) acc0 = k;
        aseen0 = d0_ram_addr;
        wseen0 = d0_ram_wdata;
      end
      re0n += int'(d0_re); we0n += int'(d0_we);
      re3n += int'(d3_re); we3n += int'(d3_we);
      if (d0_ready) begin
        rdy0n++;
        if (lat0 < 0) begin lat0 = k; rd0 = d0_data_in; end
      end
      if (d3_ready) begin
        rdy3n++;
        if (lat3 < 0) begin lat3 = k; rd3 = d3_data_in; end
      end
      // drop strobes and scramble inputs once ACCESS is reached
      if (k == 1) begin
        mem_ren = 1'b0; mem_wen = 1'b0;
        address = 16'h00EE; data_out = 16'hDEAD;
      end
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, " data_in"},   32'(d0_data_in),   0);
    chk({tag, " ready"},     32'(d0_ready),     0);
    chk({tag, " ram_addr"},  32'(d0_ram_addr),  0);
    chk({tag, " ram_wdata"}, 32'(d0_ram_wdata), 0);
    chk({tag, " ram_re"},    32'(d0_re),        0);
    chk({tag, " ram_we"},    32'(d0_we),        0);
    chk({tag, " led"},       32'(d0_led),       0);
    chk({tag, " err"},       32'(d0_err),       0);
    chk({tag, " d3 ram_we"}, 32'(d3_we),        0);
    chk({tag, " d3 err"},    32'(d3_err),       0);
    chk({tag, " d3 data"},   32'(d3_data_in),   0);
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [8];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int re0a, re0b, re3a, re3b, rd0a, rd0b, rd3a;
    tbl[0] = '{1'b1, 1'b0, 16'h0004, 16'h0000, 16'hBEEF, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 16'h0020, 16'h1234, 16'h0000, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 16'h0040, 16'hCAFE, 16'h0000, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 16'h0008, 16'h0000, 16'h1357, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'hCAFE, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 16'h0030, 16'h5555, 16'h0000, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 16'h5555, 1'b1};

    repeat (3) @(negedge clk);
    chk_rst("init");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      xfer(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d);
      chk($sformatf("v%0d lat0", i), 32'(lat0), 3);
      chk($sformatf("v%0d lat3", i), 32'(lat3), 6);
      chk($sformatf("v%0d rdy0n", i), 32'(rdy0n), 1);
      chk($sformatf("v%0d rdy3n", i), 32'(rdy3n), 1);
      chk($sformatf("v%0d acc0", i), 32'(acc0), 1);
      chk($sformatf("v%0d addr", i), 32'(aseen0), 32'(tbl[i].a));
      chk($sformatf("v%0d err0", i), 32'(d0_err), 32'(tbl[i].exp_err));
      chk($sformatf("v%0d err3", i), 32'(d3_err), 32'(tbl[i].exp_err));
      if (tbl[i].w) begin
        chk($sformatf("v%0d we0n", i), 32'(we0n), 1);
        chk($sformatf("v%0d re0n", i), 32'(re0n), 0);
        chk($sformatf("v%0d we3n", i), 32'(we3n), 1);
        chk($sformatf("v%0d wdata", i), 32'(wseen0), 32'(tbl[i].d));
        chk($sformatf("v%0d mem0", i),
            32'(mem0[tbl[i].a[7:0]]), 32'(tbl[i].d));
        chk($sformatf("v%0d mem3", i),
            32'(mem3[tbl[i].a[7:0]]), 32'(tbl[i].d));
      end else begin
        chk($sformatf("v%0d re0n", i), 32'(re0n), 1);
        chk($sformatf("v%0d we0n", i), 32'(we0n), 0);
        chk($sformatf("v%0d re3n", i), 32'(re3n), 1);
        chk($sformatf("v%0d rd0", i), 32'(rd0), 32'(tbl[i].exp_rd));
        chk($sformatf("v%0d rd3", i), 32'(rd3), 32'(tbl[i].exp_rd));
        @(negedge clk);
        chk($sformatf("v%0d hold0", i),
            32'(d0_data_in), 32'(tbl[i].exp_rd));
        chk($sformatf("v%0d hold3", i),
            32'(d3_data_in), 32'(tbl[i].exp_rd));
      end
    end

    // strobes held through DONE: next ACCESS lands at DONE+2
    re0a = -1; re0b = -1; re3a = -1; re3b = -1;
    rd0a = -1; rd0b = -1; rd3a = -1;
    @(negedge clk);
    mem_ren = 1'b1; address = 16'h0004;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (d0_re) begin
        if (re0a < 0) re0a = k; else if (re0b < 0) re0b = k;
      end
      if (d3_re) begin
        if (re3a < 0) re3a = k; else if (re3b < 0) re3b = k;
      end
      if (d0_ready) begin
        if (rd0a < 0) rd0a = k; else if (rd0b < 0) rd0b = k;
      end
      if (d3_ready && rd3a < 0) rd3a = k;
    end
    mem_ren = 1'b0;
    chk("hold re0 first", 32'(re0a), 1);
    chk("hold rdy0 first", 32'(rd0a), 3);
    chk("hold re0 second", 32'(re0b), 5);
    chk("hold rdy0 second", 32'(rd0b), 7);
    chk("hold re3 first", 32'(re3a), 1);
    chk("hold rdy3 first", 32'(rd3a), 6);
    chk("hold re3 second", 32'(re3b), 8);
    for (int k = 0; k < 20 && !d3_ready; k++) @(negedge clk);
    chk("hold d3 drained", 32'(d3_ready), 1);
    @(negedge clk);

    // reset during ACCESS of a write
    @(negedge clk);
    mem_wen = 1'b1; address = 16'h0010; data_out = 16'h7777;
    @(negedge clk);
    chk("rst pre we0", 32'(d0_we), 1);
    chk("rst pre we3", 32'(d3_we), 1);
    rst = 1'b1; mem_wen = 1'b0;
    @(negedge clk);
    chk_rst("midrst");
    rst = 1'b0;

`ifdef STUMP_MEM_IO_EN
    sw_in = 16'hA5A5;
    repeat (3) @(negedge clk);
    xfer(1'b1, 1'b0, 16'hFFF0, 16'h0000);
    chk("io sw rd", 32'(rd0), 32'h0000A5A5);
    chk("io sw lat", 32'(lat0), 3);
    chk("io sw re", 32'(re0n), 0);
    xfer(1'b0, 1'b1, 16'hFFF1, 16'h00FF);
    chk("io led0", 32'(d0_led), 32'h000000FF);
    chk("io led3", 32'(d3_led), 32'h000000FF);
    chk("io led we", 32'(we0n + we3n), 0);
    chk("io led lat3", 32'(lat3), 6);
    xfer(1'b1, 1'b0, 16'hFFF1, 16'h0000);
    chk("io led rd", 32'(rd0), 32'h000000FF);
    xfer(1'b1, 1'b0, 16'hFF80, 16'h0000);
    chk("io other rd0", 32'(rd0), 0);
    chk("io other rd3", 32'(rd3), 0);
`else
    sw_in = 16'hA5A5;
    xfer(1'b0, 1'b1, 16'hFFF1, 16'h00FF);
    chk("noio we", 32'(we0n), 1);
    chk("noio led", 32'(d0_led), 0);
    xfer(1'b1, 1'b0, 16'hFFF1, 16'h0000);
    chk("noio rd", 32'(rd0), 32'h000000FF);
    chk("noio re", 32'(re0n), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
